stream_demux4: RTL and testbench

STREAM_DEMUX4 -- requirements
Module: stream_demux4

---
 rtl/stream_demux4.sv | 112 +++++++++++
 tb/tb_stream_demux4.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stream_demux4.sv
// Four-way stream demultiplexer: each upstream word is routed by up_sel into
// one of four independent per-port FIFO queues with ready/valid handshakes.
module stream_demux4 #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               up_valid,
   input  logic [1:0]         up_sel,
   input  logic [WIDTH-1:0]   up_data,
   output logic               up_ready,
   output logic [3:0]         dn_valid,
   output logic [4*WIDTH-1:0] dn_data,
   input  logic [3:0]         dn_ready,
   output logic               busy
);

   localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_r    [4][DEPTH];
   logic [PW-1:0]    wr_ptr_r [4];
   logic [PW-1:0]    rd_ptr_r [4];
   logic [CW-1:0]    count_r  [4];
   logic [3:0]       full_s;
   logic [3:0]       push_s;
   logic [3:0]       pop_s;

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths stay correct.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (ptr == LAST_PTR) begin
         nxt = {PW{1'b0}};
      end else begin
         nxt = ptr + PW'(1);
      end
      return nxt;
   endfunction

   // Queue status flags derived from the registered occupancy counts only.
   always_comb begin
      full_s   = 4'b0000;
      dn_valid = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         full_s[i]   = (count_r[i] == FULL_CNT);
         dn_valid[i] = (count_r[i] != {CW{1'b0}});
      end
   end

   assign up_ready = ~full_s[up_sel];
   assign busy     = |dn_valid;

   // Handshake qualification per port; up_sel only matters when up_valid is high.
   always_comb begin
      push_s = 4'b0000;
      pop_s  = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (up_valid && up_ready && (up_sel == 2'(i))) begin
            push_s[i] = 1'b1;
         end else begin
            push_s[i] = 1'b0;
         end
         pop_s[i] = dn_valid[i] & dn_ready[i];
      end
   end

   // Head words are read straight from the storage registers.
   always_comb begin
      dn_data = {(4*WIDTH){1'b0}};
      for (int i = 0; i < 4; i++) begin
         dn_data[i*WIDTH +: WIDTH] = mem_r[i][rd_ptr_r[i]];
      end
   end

   // Storage array needs no reset: validity is tracked by the counts.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (push_s[i]) begin
            mem_r[i][wr_ptr_r[i]] <= up_data;
         end
      end
   end

   // Pointer and occupancy bookkeeping; reset empties every queue at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            wr_ptr_r[i] <= {PW{1'b0}};
            rd_ptr_r[i] <= {PW{1'b0}};
            count_r[i]  <= {CW{1'b0}};
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (push_s[i]) begin
               wr_ptr_r[i] <= next_ptr(wr_ptr_r[i]);
            end
            if (pop_s[i]) begin
               rd_ptr_r[i] <= next_ptr(rd_ptr_r[i]);
            end
            case ({push_s[i], pop_s[i]})
               2'b10:   count_r[i] <= count_r[i] + CW'(1);
               2'b01:   count_r[i] <= count_r[i] - CW'(1);
               default: count_r[i] <= count_r[i];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stream_demux4.sv
// Self-checking bench for stream_demux4: directed scenarios plus random traffic
// compared against four behavioural word queues.
module tb_stream_demux4;

   localparam int WIDTH = 8;
   localparam int DEPTH = 2;

   logic               clk;
   logic               rst_n;
   logic               up_valid;
   logic [1:0]         up_sel;
   logic [WIDTH-1:0]   up_data;
   logic               up_ready;
   logic [3:0]         dn_valid;
   logic [4*WIDTH-1:0] dn_data;
   logic [3:0]         dn_ready;
   logic               busy;

   int n_checks = 0;
   int n_errors = 0;
   logic [WIDTH-1:0] model_q [4][$];

   stream_demux4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .up_sel   (up_sel),
      .up_data  (up_data),
      .up_ready (up_ready),
      .dn_valid (dn_valid),
      .dn_data  (dn_data),
      .dn_ready (dn_ready),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [3:0] exp_valid;
      exp_valid = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         exp_valid[i] = (model_q[i].size() > 0);
         if (model_q[i].size() > 0) begin
            check_eq($sformatf("dn_data%0d", i), 32'(dn_data[i*WIDTH +: WIDTH]), 32'(model_q[i][0]));
         end
      end
      check_eq("dn_valid", 32'(dn_valid), 32'(exp_valid));
      check_eq("busy", 32'(busy), 32'(|exp_valid));
   endtask

   // One clock cycle: drive, check up_ready, apply the model at the edge, check outputs.
   task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic [3:0] r);
      logic exp_rdy;
      up_valid = v;
      up_sel   = s;
      up_data  = v ? d : 'x;
      dn_ready = r;
      #1;
      exp_rdy = (model_q[s].size() < DEPTH);
      check_eq("up_ready", 32'(up_ready), 32'(exp_rdy));
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (r[i] && model_q[i].size() > 0) begin
            void'(model_q[i].pop_front());
         end
      end
      if (v && exp_rdy) begin
         model_q[s].push_back(d);
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drain();
      for (int k = 0; k < DEPTH + 1; k++) begin
         step(1'b0, 2'd0, 8'h00, 4'b1111);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      up_valid = 1'b0;
      up_sel   = 2'd0;
      up_data  = 8'h00;
      dn_ready = 4'b0000;
      #1;
      check_eq("rst_dn_valid", 32'(dn_valid), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_up_ready", 32'(up_ready), 32'h1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Route one word to each port.
      step(1'b1, 2'd0, 8'h11, 4'b1111);
      check_eq("route_v0", 32'(dn_valid), 32'h1);
      step(1'b1, 2'd1, 8'h22, 4'b1111);
      check_eq("route_v1", 32'(dn_valid), 32'h2);
      check_eq("route_d1", 32'(dn_data[15:8]), 32'h22);
      step(1'b1, 2'd2, 8'h33, 4'b1111);
      step(1'b1, 2'd3, 8'h44, 4'b1111);
      check_eq("route_d3", 32'(dn_data[31:24]), 32'h44);
      drain();

      // Fill port 2, then release it; no pass-through while full.
      step(1'b1, 2'd2, 8'hA0, 4'b0000);
      step(1'b1, 2'd2, 8'hA1, 4'b0000);
      step(1'b1, 2'd2, 8'hA2, 4'b0000);
      check_eq("fill_head", 32'(dn_data[23:16]), 32'hA0);
      up_valid = 1'b1; up_sel = 2'd2; up_data = 8'hA2; dn_ready = 4'b0100;
      #1;
      check_eq("fill_full_ready", 32'(up_ready), 32'h0);
      step(1'b1, 2'd2, 8'hA2, 4'b0100);
      check_eq("fill_head_a1", 32'(dn_data[23:16]), 32'hA1);
      step(1'b1, 2'd2, 8'hA2, 4'b0100);
      check_eq("fill_head_a2", 32'(dn_data[23:16]), 32'hA2);
      step(1'b0, 2'd2, 8'h00, 4'b0100);
      check_eq("fill_empty", 32'(dn_valid), 32'h0);

      // Full port 1 must not block port 3.
      step(1'b1, 2'd1, 8'hB0, 4'b0000);
      step(1'b1, 2'd1, 8'hB1, 4'b0000);
      step(1'b1, 2'd3, 8'h5C, 4'b0000);
      check_eq("iso_valid", 32'(dn_valid), 32'hA);
      check_eq("iso_d3", 32'(dn_data[31:24]), 32'h5C);
      drain();

      // Simultaneous push and pop keeps occupancy at one.
      step(1'b1, 2'd0, 8'h66, 4'b0000);
      step(1'b1, 2'd0, 8'h77, 4'b0001);
      check_eq("sim_valid", 32'(dn_valid), 32'h1);
      check_eq("sim_head", 32'(dn_data[7:0]), 32'h77);
      drain();

      // Reset pulse between edges discards ports 0 and 3.
      step(1'b1, 2'd0, 8'hC0, 4'b0000);
      step(1'b1, 2'd3, 8'hC3, 4'b0000);
      up_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(dn_valid), 32'h0);
      check_eq("mid_rst_busy", 32'(busy), 32'h0);
      for (int i = 0; i < 4; i++) model_q[i].delete();
      up_valid = 1'b1; up_sel = 2'd1; up_data = 8'hEE;
      #1;
      check_eq("mid_rst_ready", 32'(up_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_no_xfer", 32'(dn_valid), 32'h0);
      rst_n = 1'b1;
      step(1'b1, 2'd0, 8'hE1, 4'b0000);
      check_eq("post_rst_valid", 32'(dn_valid), 32'h1);
      check_eq("post_rst_d0", 32'(dn_data[7:0]), 32'hE1);
      drain();

      // Random traffic against the queue model.
      for (int k = 0; k < 10000; k++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
              4'($urandom));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
